// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: key-length and FSM encodings, per-length
// lookups, round-constant arithmetic and the forward S-box.
package aes_key_pkg;

  typedef enum logic [1:0] {
    KEY128 = 2'd0,
    KEY192 = 2'd1,
    KEY256 = 2'd2
  } key_len_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (key_len_t'(len))
      KEY128:  return 4'd4;
      KEY192:  return 4'd6;
      KEY256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (key_len_t'(len))
      KEY128:  return 4'd10;
      KEY192:  return 4'd12;
      KEY256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Entry x sits at bit offset 8*(255-x); 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_key_expander_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_key_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: expands one word per cycle into a local store
// and serves 128-bit round keys through a registered read port.
module aes_key_expander
  import aes_key_pkg::*;
#(
  parameter int MAX_NK    = 8,
  parameter int RK_ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [1:0]             key_len,
  input  logic [32*MAX_NK-1:0]   key_in,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  input  logic                   rd_en,
  input  logic [RK_ADDR_W-1:0]   rd_addr,
  output logic                   rd_valid,
  output logic [127:0]           rd_data,
  output logic                   rd_err,
  output logic [3:0]             nr
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);

  logic [31:0]   w_mem [DEPTH];
  state_t        state;
  logic [AW-1:0] idx;
  logic [3:0]    nk_r;
  logic [2:0]    phase;
  logic [7:0]    rcon;
  logic [AW-1:0] last_idx;

  logic [3:0]    nk_req;
  logic          start_ok;
  logic          start_bad;

  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   w_new;

  logic [AW-1:0] rd_base;
  logic          rd_legal;

  // Starts are only considered outside EXPAND; during expansion they are dropped silently.
  assign nk_req    = nk_of(key_len);
  assign start_ok  = start && (state != EXPAND) && (key_len != 2'd3) &&
                     (int'(nk_req) <= MAX_NK);
  assign start_bad = start && (state != EXPAND) && !start_ok;

  assign last_idx  = AW'(4 * int'(nr) + 3);

  // phase tracks i mod Nk so no divider is needed for the 6-word case.
  assign w_prev = w_mem[idx - AW'(1)];
  assign w_back = w_mem[idx - AW'(nk_r)];
  assign sub_in = (phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((nk_r == 4'd8) && (phase == 3'd4)) begin
      temp = sub_out;
    end
  end

  assign w_new = w_back ^ temp;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      idx     <= '0;
      nk_r    <= '0;
      phase   <= '0;
      rcon    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      nr      <= '0;
    end else begin
      cfg_err <= start_bad;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state <= EXPAND;
            idx   <= AW'(nk_req);
            nk_r  <= nk_req;
            phase <= 3'd0;
            rcon  <= RCON_INIT;
            busy  <= 1'b1;
            done  <= 1'b0;
            nr    <= nr_of(key_len);
          end
        end
        EXPAND: begin
          idx   <= idx + AW'(1);
          phase <= ({1'b0, phase} == nk_r - 4'd1) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) begin
            rcon <= xtime(rcon);
          end
          if (idx == last_idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The store is deliberately not reset; done gates every read of it.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(nk_req)) begin
          w_mem[k] <= key_in[32*(MAX_NK-1-k) +: 32];
        end
      end
    end else if (state == EXPAND) begin
      w_mem[idx] <= w_new;
    end
  end

  assign rd_base  = AW'({rd_addr, 2'b00});
  assign rd_legal = done && (int'(rd_addr) <= int'(nr));

  // Reads see registered done/store, so a read coinciding with a new start returns the old schedule.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_legal;
      if (rd_en) begin
        rd_data <= rd_legal ? {w_mem[rd_base], w_mem[rd_base + AW'(1)],
                               w_mem[rd_base + AW'(2)], w_mem[rd_base + AW'(3)]}
                            : 128'h0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 vectors, random keys against a
// GF(2^8)-derived reference schedule, and the multi-cycle corner cases.
module tb_aes_key_expander;

  localparam int MAX_NK = 8;
  localparam int KW     = 32 * MAX_NK;
  localparam int W      = 130;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start, rd_en;
  logic [1:0]    key_len;
  logic [KW-1:0] key_in;
  logic [3:0]    rd_addr;
  logic          busy, done, cfg_err, rd_valid, rd_err;
  logic [127:0]  rd_data;
  logic [3:0]    nr;

  logic          start4, rd_en4;
  logic [1:0]    key_len4;
  logic [127:0]  key_in4;
  logic [3:0]    rd_addr4;
  logic          busy4, done4, cfg_err4, rd_valid4, rd_err4;
  logic [127:0]  rd_data4;
  logic [3:0]    nr4;

  always #5 clk = ~clk;

  aes_key_expander #(.MAX_NK(MAX_NK), .RK_ADDR_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .nr(nr)
  );

  aes_key_expander #(.MAX_NK(4), .RK_ADDR_W(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start4), .key_len(key_len4), .key_in(key_in4),
    .busy(busy4), .done(done4), .cfg_err(cfg_err4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_err(rd_err4), .nr(nr4)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box from the GF(2^8) inverse plus affine map, schedule from FIPS-197 rules.
  logic [7:0]  sbox_ref [256];
  logic [31:0] ref_w [60];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x[7:0]);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
    return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
  endfunction

  task automatic expand_ref(input logic [1:0] len, input logic [KW-1:0] key);
    int nk, total;
    logic [7:0]  rc;
    logic [31:0] t;
    nk    = 4 + 2 * int'(len);
    total = 4 * (nk + 7);
    for (int k = 0; k < nk; k++) ref_w[k] = key[KW-1-32*k -: 32];
    rc = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word_ref(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  // Driver tasks; all inputs change on the falling edge.
  task automatic drive_start(input logic [1:0] len, input logic [KW-1:0] key);
    @(negedge clk); start = 1'b1; key_len = len; key_in = key;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_one(input logic [3:0] a, output logic [W-1:0] got);
    @(negedge clk); rd_en = 1'b1; rd_addr = a;
    @(negedge clk); rd_en = 1'b0;
    got = {rd_valid, rd_err, rd_data};
  endtask

  // Back-to-back reads of addresses lo..hi, then confirm rd_data holds once rd_en drops.
  task automatic read_seq(input int lo, input int hi, input bit sched_ok, input int nr_i,
                          input string name);
    logic [W-1:0] e, last;
    last = '0;
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (a > lo) check(name, {rd_valid, rd_err, rd_data}, exp_q.pop_front());
      if (a <= hi) begin
        rd_en = 1'b1; rd_addr = a[3:0];
        e = (sched_ok && a <= nr_i) ? {2'b10, ref_rk(a)} : {2'b11, 128'h0};
        exp_q.push_back(e);
        last = e;
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    check({name, "_hold"}, {rd_valid, rd_data}, {1'b0, last[127:0]});
  endtask

  typedef struct {
    logic [1:0]    len;
    logic [KW-1:0] key;
    logic [3:0]    addr;
    logic [127:0]  rk;
    int            lat;
    logic [3:0]    nr_exp;
  } vec_t;

  vec_t vecs[4];

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  got;
    logic [KW-1:0] key, key_a, key_b;
    logic [127:0]  old_rk0;
    int            cyc, nk_i, nr_i;
    logic [1:0]    len;

    build_sbox();
    start = 1'b0; rd_en = 1'b0; key_len = 2'd0; key_in = '0; rd_addr = '0;
    start4 = 1'b0; rd_en4 = 1'b0; key_len4 = 2'd0; key_in4 = '0; rd_addr4 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, cfg_err, rd_valid, rd_err, rd_data, nr}, '0);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {busy, done, cfg_err, rd_valid, rd_err, rd_data, nr}, '0);
    read_one(4'd0, got);
    check("read_before_done", got, {2'b11, 128'h0});

    // FIPS-197 vectors; unused low key words carry junk that must be ignored
    vecs[0] = '{2'd0, {K128, 128'h0}, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 40, 4'd10};
    vecs[1] = '{2'd0, {K128, 128'h0}, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40, 4'd10};
    vecs[2] = '{2'd1, {K192, 64'h0},  4'd12, 128'he98ba06f448c773c8ecc720401002202, 46, 4'd12};
    vecs[3] = '{2'd2, K256,           4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 52, 4'd14};
    vecs[0].key[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    vecs[2].key[63:0]  = {$urandom(), $urandom()};

    for (int v = 0; v < 4; v++) begin
      drive_start(vecs[v].len, vecs[v].key);
      check("busy_after_start", {busy, done}, 2'b10);
      wait_done(cyc);
      check("fips_latency", cyc, vecs[v].lat);
      check("fips_nr", nr, vecs[v].nr_exp);
      read_one(vecs[v].addr, got);
      check("fips_round_key", got, {2'b10, vecs[v].rk});
      expand_ref(vecs[v].len, vecs[v].key);
      read_seq(0, int'(vecs[v].nr_exp), 1'b1, int'(vecs[v].nr_exp), "fips_schedule");
    end

    // Rejected key_len=3 in DONE: one pulse, schedule kept
    drive_start(2'd3, '0);
    check("cfg_err_pulse", {cfg_err, busy, done}, 3'b101);
    @(negedge clk);
    check("cfg_err_one_cycle", {cfg_err, busy, done, nr}, {3'b001, 4'd14});
    read_one(4'd14, got);
    check("schedule_kept_after_reject", got, {2'b10, ref_rk(14)});

    // AES-128 then illegal address
    drive_start(2'd0, {K128, 128'h0});
    wait_done(cyc);
    read_one(4'd11, got);
    check("illegal_addr_11", got, {2'b11, 128'h0});
    read_one(4'd15, got);
    check("illegal_addr_15", got, {2'b11, 128'h0});

    // Read while busy
    drive_start(2'd1, {K192, 64'h0});
    read_one(4'd0, got);
    check("read_while_busy", got, {2'b11, 128'h0});
    wait_done(cyc);
    check("latency_with_busy_read", cyc + 2, 46);

    // Simultaneous start and read in DONE returns the old schedule
    expand_ref(2'd1, {K192, 64'h0});
    old_rk0 = ref_rk(0);
    key_a = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; key_in = key_a; rd_en = 1'b1; rd_addr = 4'd0;
    @(negedge clk);
    start = 1'b0; rd_en = 1'b0;
    check("read_at_start_old_key", {rd_valid, rd_err, rd_data}, {2'b10, old_rk0});
    wait_done(cyc);
    check("latency_after_read_start", cyc, 40);
    expand_ref(2'd0, key_a);
    read_seq(0, 10, 1'b1, 10, "new_schedule");

    // Start during EXPAND is ignored
    key_b = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 64'h0};
    drive_start(2'd0, key_a);
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      if (k == 5) check("no_cfg_err_in_expand", {cfg_err, busy}, 2'b01);
      if (k == 4) begin start = 1'b1; key_len = 2'd3; key_in = key_b; end
      else if (k == 6) begin start = 1'b1; key_len = 2'd1; key_in = key_b; end
      else start = 1'b0;
    end
    begin
      int more;
      wait_done(more);
      check("latency_ignored_start", cyc + more, 40);
    end
    check("nr_ignored_start", nr, 4'd10);
    read_seq(0, 10, 1'b1, 10, "ignored_start_schedule");

    // Reset 20 cycles into expansion, then a clean restart
    drive_start(2'd2, K256);
    repeat (20) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_expand_reset", {busy, done, cfg_err, rd_valid, rd_err, rd_data, nr}, '0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("no_resume_after_reset", {busy, done}, 2'b00);
    drive_start(2'd0, {K128, 128'h0});
    wait_done(cyc);
    check("latency_after_reset", cyc, 40);
    expand_ref(2'd0, {K128, 128'h0});
    read_seq(0, 10, 1'b1, 10, "schedule_after_reset");

    // Random keys; reads cover every address so the nr boundary is exercised
    for (int r = 0; r < 6; r++) begin
      len = 2'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom();
      nk_i = 4 + 2 * int'(len);
      nr_i = nk_i + 6;
      drive_start(len, key);
      wait_done(cyc);
      check("rand_latency", cyc, 4 * (nr_i + 1) - nk_i);
      check("rand_nr", nr, nr_i);
      expand_ref(len, key);
      read_seq(0, 15, 1'b1, nr_i, "rand_schedule");
    end

    // Build with MAX_NK=4 rejects longer keys but runs AES-128
    @(negedge clk); start4 = 1'b1; key_len4 = 2'd2;
    @(negedge clk); start4 = 1'b0;
    check("nk4_reject_256", {cfg_err4, busy4, done4}, 3'b100);
    @(negedge clk);
    check("nk4_reject_one_cycle", {cfg_err4, busy4, done4}, 3'b000);
    @(negedge clk); start4 = 1'b1; key_len4 = 2'd1;
    @(negedge clk); start4 = 1'b0;
    check("nk4_reject_192", {cfg_err4, busy4, done4}, 3'b100);
    @(negedge clk); start4 = 1'b1; key_len4 = 2'd0; key_in4 = K128;
    @(negedge clk); start4 = 1'b0;
    check("nk4_accept_128", {cfg_err4, busy4}, 2'b01);
    cyc = 0;
    while (!done4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("nk4_latency", cyc, 40);
    @(negedge clk); rd_en4 = 1'b1; rd_addr4 = 4'd10;
    @(negedge clk); rd_en4 = 1'b0;
    check("nk4_round10", {rd_valid4, rd_err4, rd_data4},
          {2'b10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
